// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch squash and mult/div EX
// occupancy, with a saturating stall-cycle counter for performance debug.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRt,
  input  logic        IdMultiCycle,
  input  logic        ExMemtoReg,
  input  logic [4:0]  ExRt,
  input  logic        ExBranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXWrite,
  output logic        IDEXFlush,
  output logic        MDBusy,
  output logic        MDDone,
  output logic [15:0] StallCnt
);

  localparam int unsigned SC_W = 16;
  localparam logic [SC_W-1:0] SC_MAX = '1;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SC_W-1:0]  stall_cnt_q;
  logic             lu;
  logic             br;

  // $zero destinations never create a load-use dependence
  assign lu = ExMemtoReg & (ExRt != 5'd0) &
              ((ExRt == IdRs) | (IdUsesRt & (ExRt == IdRt)));
  assign br = ExBranchTaken;

  // Pipeline controls are combinational so the registers act on this edge
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXWrite = 1'b1;
    IDEXFlush = 1'b0;
    MDBusy    = 1'b0;
    MDDone    = 1'b0;
    if (rst) begin
      PCWrite   = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (state_q == MD_BUSY) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXWrite = 1'b0;
      MDBusy    = 1'b1;
      MDDone    = (cnt_q == CNT_W'(1));
    end else if (br) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (lu) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

  // State, occupancy counter and stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!PCWrite && (stall_cnt_q != SC_MAX)) begin
        stall_cnt_q <= stall_cnt_q + SC_W'(1);
      end
      case (state_q)
        RUN: begin
          if (!br && !lu && IdMultiCycle) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_W'(MD_CYCLES - 1);
          end
        end
        MD_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus a stall-counter saturation run.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        IdUsesRt;
  logic        IdMultiCycle;
  logic        ExMemtoReg;
  logic [4:0]  ExRt;
  logic        ExBranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXWrite;
  logic        IDEXFlush;
  logic        MDBusy;
  logic        MDDone;
  logic [15:0] StallCnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt), .IdMultiCycle(IdMultiCycle),
    .ExMemtoReg(ExMemtoReg), .ExRt(ExRt), .ExBranchTaken(ExBranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush),
    .MDBusy(MDBusy), .MDDone(MDDone), .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MDBusy, MDDone}
  localparam logic [6:0] C_RST  = 7'b0111100;
  localparam logic [6:0] C_RUN  = 7'b1101000;
  localparam logic [6:0] C_LU   = 7'b0001100;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_BSY  = 7'b0000010;
  localparam logic [6:0] C_DONE = 7'b0000011;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses;
    logic        multi;
    logic        mtr;
    logic [4:0]  exrt;
    logic        br;
    logic [6:0]  ctl;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic multi, input logic mtr,
                              input logic [4:0] exrt, input logic br,
                              input logic [6:0] ctl, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.uses = uses; v.multi = multi;
    v.mtr = mtr; v.exrt = exrt; v.br = br; v.ctl = ctl; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; IdRs = v.rs; IdRt = v.rt; IdUsesRt = v.uses;
    IdMultiCycle = v.multi; ExMemtoReg = v.mtr; ExRt = v.exrt; ExBranchTaken = v.br;
  endtask

  task automatic check_ctl(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, MDBusy, MDDone};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ctl got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (StallCnt !== exp) begin
      errors++;
      $display("FAIL %s StallCnt got %h want %h", name, StallCnt, exp);
    end
  endtask

  initial begin
    // rst, rs, rt, uses, multi, mtr, exrt, br, ctl, StallCnt before edge
    vecs[0]  = mk(1, 1, 2, 1, 0, 0, 0, 0, C_RST,  16'd0); // reset outputs
    vecs[1]  = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd0); // no hazard
    vecs[2]  = mk(0, 8, 2, 1, 0, 1, 8, 0, C_LU,   16'd0); // load-use on rs
    vecs[3]  = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd1); // bubble, resume
    vecs[4]  = mk(0, 3, 9, 0, 0, 1, 9, 0, C_RUN,  16'd1); // rt match, rt unused
    vecs[5]  = mk(0, 3, 9, 1, 0, 1, 9, 0, C_LU,   16'd1); // rt match, rt used
    vecs[6]  = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd2);
    vecs[7]  = mk(0, 0, 0, 1, 0, 1, 0, 0, C_RUN,  16'd2); // $zero load harmless
    vecs[8]  = mk(0, 8, 2, 1, 0, 1, 8, 1, C_BR,   16'd2); // branch beats load-use
    vecs[9]  = mk(0, 8, 2, 1, 1, 1, 8, 1, C_BR,   16'd2); // branch squashes mult
    vecs[10] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd2); // still RUN
    vecs[11] = mk(0, 1, 2, 1, 1, 0, 0, 0, C_RUN,  16'd2); // mult enters EX
    vecs[12] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_BSY,  16'd2); // busy 1
    vecs[13] = mk(0, 8, 2, 1, 1, 1, 8, 1, C_BSY,  16'd3); // busy 2, inputs ignored
    vecs[14] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_DONE, 16'd4); // busy 3, done
    vecs[15] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd5); // RUN resumes
    vecs[16] = mk(0, 8, 2, 1, 1, 1, 8, 0, C_LU,   16'd5); // load-use blocks mult
    vecs[17] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd6); // not busy
    vecs[18] = mk(0, 1, 2, 1, 1, 0, 0, 0, C_RUN,  16'd6); // mult enters EX
    vecs[19] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_BSY,  16'd6); // busy 1
    vecs[20] = mk(1, 1, 2, 1, 0, 0, 0, 0, C_RST,  16'd7); // reset mid-op
    vecs[21] = mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN,  16'd0); // aborted, cleared

    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #3;
      check_ctl($sformatf("vec%0d", i), vecs[i].ctl);
      check_cnt($sformatf("vec%0d", i), vecs[i].cnt);
      @(posedge clk);
      #1;
    end

    // Saturation: hold a load-use condition so every edge is a stall
    drive(mk(0, 8, 2, 1, 0, 1, 8, 0, C_LU, 16'd0));
    repeat (65534) @(posedge clk);
    #1;
    check_cnt("sat_fffe", 16'hFFFE);
    check_ctl("sat_stall", C_LU);
    @(posedge clk);
    #1;
    check_cnt("sat_ffff", 16'hFFFF);
    repeat (4466) @(posedge clk);
    #1;
    check_cnt("sat_hold", 16'hFFFF);
    drive(mk(0, 1, 2, 1, 0, 0, 0, 0, C_RUN, 16'd0));
    #1;
    check_ctl("sat_release", C_RUN);
    @(posedge clk);
    #1;
    check_cnt("sat_after", 16'hFFFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_cnt("sat_reset", 16'd0);
    check_ctl("sat_reset", C_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
